// File: rtl/instr_fetch_pkg.sv
// Shared types and helpers for the fetch stage: FSM state encoding, the
// decoder/ALU redirect bundle and the next-PC source selector.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_ISSUE = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_REG    = 2'd3
   } next_sel_t;

   localparam logic [31:0] PC_STEP    = 32'd4;
   localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

   typedef struct packed {
      logic        reg_jump;
      logic [31:0] reg_target;
      logic        is_jump;
      logic [25:0] addr26;
      logic        is_branch;
      logic        branch_taken;
      logic [15:0] imm16;
   } redirect_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_MASK;
   endfunction

   // Branch offsets count words, so the sign-extended field is scaled by 4.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response handshake between the fetch stage
// (master) and the instruction memory (slave).
interface instr_fetch_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: register jump, absolute jump, taken
// branch, or sequential, in that priority order.
module pc_next
   import instr_fetch_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  redirect_t   redirect,
   output logic [31:0] next_pc
);

   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [31:0] reg_target_aligned;
   next_sel_t   sel;

   always_comb begin
      jump_target        = {pc_plus4[31:28], redirect.addr26, 2'b00};
      branch_target      = pc_plus4 + branch_offset(redirect.imm16);
      reg_target_aligned = word_align(redirect.reg_target);

      if (redirect.reg_jump) begin
         sel = SEL_REG;
      end else if (redirect.is_jump) begin
         sel = SEL_JUMP;
      end else if (redirect.is_branch && redirect.branch_taken) begin
         sel = SEL_BRANCH;
      end else begin
         sel = SEL_SEQ;
      end

      unique case (sel)
         SEL_REG:    next_pc = reg_target_aligned;
         SEL_JUMP:   next_pc = jump_target;
         SEL_BRANCH: next_pc = branch_target;
         default:    next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over the imem
// handshake and holds it in the instruction register for the decoder.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master imem,
   output logic [31:0]   instruction,
   output logic          instr_valid,
   output logic [31:0]   pc,
   output logic [31:0]   pc_plus4,
   input  logic          stall,
   input  logic          is_jump,
   input  logic [25:0]   addr26,
   input  logic          is_branch,
   input  logic          branch_taken,
   input  logic [15:0]   imm16,
   input  logic          reg_jump,
   input  logic [31:0]   reg_target,
   output logic [31:0]   fetch_count
);

   localparam logic [31:0] BOOT_PC = word_align(RESET_PC);

   fetch_state_t state;
   logic [31:0]  pc_q;
   logic [31:0]  instruction_q;
   logic [31:0]  count_q;
   logic         req_valid_q;
   logic         instr_valid_q;
   logic [31:0]  next_pc;
   redirect_t    redirect;

   assign redirect = '{
      reg_jump:     reg_jump,
      reg_target:   reg_target,
      is_jump:      is_jump,
      addr26:       addr26,
      is_branch:    is_branch,
      branch_taken: branch_taken,
      imm16:        imm16
   };

   assign pc_plus4 = pc_q + PC_STEP;

   pc_next u_pc_next (
      .pc_plus4 (pc_plus4),
      .redirect (redirect),
      .next_pc  (next_pc)
   );

   // Handshake flags are registered next to the state so they always match
   // the state they describe; redirects only matter when an issue retires.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_BOOT;
         pc_q          <= BOOT_PC;
         instruction_q <= '0;
         count_q       <= '0;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         unique case (state)
            S_BOOT: begin
               state       <= S_REQ;
               req_valid_q <= 1'b1;
            end
            S_REQ: begin
               if (imem.imem_req_ready) begin
                  state       <= S_WAIT;
                  req_valid_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem.imem_resp_valid) begin
                  instruction_q <= imem.imem_resp_data;
                  state         <= S_ISSUE;
                  instr_valid_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (!stall) begin
                  pc_q          <= next_pc;
                  count_q       <= count_q + 32'd1;
                  state         <= S_REQ;
                  instr_valid_q <= 1'b0;
                  req_valid_q   <= 1'b1;
               end
            end
            default: begin
               state         <= S_BOOT;
               req_valid_q   <= 1'b0;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req_valid = req_valid_q;
   assign imem.imem_addr      = pc_q;
   assign instruction         = instruction_q;
   assign instr_valid         = instr_valid_q;
   assign pc                  = pc_q;
   assign fetch_count         = count_q;

endmodule
